// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: datapath width, NOP encoding and the fetch FSM encoding.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_timeout_counter.sv
// Counts REQ cycles spent waiting for imem_ack; flag is high once the count reaches ACK_TIMEOUT.
module instruction_fetch_timeout_counter #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       flag
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign flag = (cnt == 8'(ACK_TIMEOUT));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one imem request per phase_fetch and presents inst/PC to decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              ACK_TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            phase_update,
  input  logic            jump_en_ex,
  input  logic [XLEN-1:0] jump_addr_ex,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_done,
  output logic            fetch_busy,
  output logic            misalign_err,
  output logic            bus_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_target;
  logic            start;
  logic            timeout;
  logic [7:0]      wait_cnt;

  assign start = (state == ST_IDLE) && phase_fetch && !misalign_err && !bus_err;

  always_comb begin
    pc_target = next_pc_fd;
    if (jump_en_ex) pc_target = {jump_addr_ex[XLEN-1:1], 1'b0};
  end

  instruction_fetch_timeout_counter #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clear(start),
    .inc  ((state == ST_REQ) && !imem_ack),
    .cnt  (wait_cnt),
    .flag (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_VECTOR;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_VECTOR;
      inst         <= INST_NOP;
      curr_pc_fd   <= RESET_VECTOR;
      next_pc_fd   <= RESET_VECTOR + 32'd4;
      fetch_done   <= 1'b0;
      fetch_busy   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_REQ;
            imem_req   <= 1'b1;
            imem_addr  <= pc;
            fetch_busy <= 1'b1;
          end
        end
        ST_REQ: begin
          // Ack wins over a timeout landing on the same cycle.
          if (imem_ack) begin
            state      <= ST_DONE;
            inst       <= imem_rdata;
            curr_pc_fd <= imem_addr;
            next_pc_fd <= imem_addr + 32'd4;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b1;
          end else if (timeout) begin
            state      <= ST_ERR;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            bus_err    <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          fetch_done <= 1'b0;
        end
        default: state <= ST_ERR;
      endcase

      if (phase_update) begin
        if (pc_target[1]) misalign_err <= 1'b1;
        else              pc           <= pc_target;
      end
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^wait_cnt;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phase_fetch = 1'b0;
  logic        phase_update = 1'b0;
  logic        jump_en_ex = 1'b0;
  logic [31:0] jump_addr_ex = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        fetch_done;
  logic        fetch_busy;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int passed = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .phase_fetch(phase_fetch), .phase_update(phase_update),
    .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst(inst), .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd),
    .fetch_done(fetch_done), .fetch_busy(fetch_busy),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] i, input logic [31:0] c,
                                  input logic [31:0] n);
    chk({tag, "_inst"}, inst, i);
    chk({tag, "_curr"}, curr_pc_fd, c);
    chk({tag, "_next"}, next_pc_fd, n);
  endtask

  initial begin
    // 1: reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("reset", 32'h0000_0013, 32'h0, 32'h4);
    chk("reset_req", 32'(imem_req), 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_done", 32'(fetch_done), 32'h0);
    chk("reset_busy", 32'(fetch_busy), 32'h0);
    chk("reset_errs", {30'h0, misalign_err, bus_err}, 32'h0);

    // stray ack in IDLE changes nothing
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("idle_ack_inst", inst, 32'h0000_0013);
    chk("idle_ack_done", 32'(fetch_done), 32'h0);

    // 2: fetch at 0, ack on the third REQ cycle
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("f1_req_c1", 32'(imem_req), 32'h1);
    chk("f1_busy_c1", 32'(fetch_busy), 32'h1);
    chk("f1_addr_c1", imem_addr, 32'h0);
    tick();
    chk("f1_req_c2", 32'(imem_req), 32'h1);
    tick();
    chk("f1_req_c3", 32'(imem_req), 32'h1);
    chk("f1_addr_c3", imem_addr, 32'h0);
    chk("f1_done_c3", 32'(fetch_done), 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("f1_done", 32'(fetch_done), 32'h1);
    chk("f1_req_off", 32'(imem_req), 32'h0);
    chk("f1_busy_off", 32'(fetch_busy), 32'h0);
    chk_idle_outputs("f1", 32'h0050_0093, 32'h0, 32'h4);
    phase_fetch = 1'b1;  // arrives in DONE, must be dropped
    tick();
    phase_fetch = 1'b0;
    chk("f1_done_pulse", 32'(fetch_done), 32'h0);
    tick();
    chk("f1_no_queue", 32'(imem_req), 32'h0);

    // 3: jump to 0x101 -> pc 0x100, minimum-latency fetch
    phase_update = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0101;
    tick();
    phase_update = 1'b0; jump_en_ex = 1'b0;
    chk("j_misalign", 32'(misalign_err), 32'h0);
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("f2_addr", imem_addr, 32'h0000_0100);
    imem_ack = 1'b1; imem_rdata = 32'h0020_8133;
    tick();
    imem_ack = 1'b0;
    chk("f2_done", 32'(fetch_done), 32'h1);
    chk_idle_outputs("f2", 32'h0020_8133, 32'h100, 32'h104);
    tick();

    // 5: wrap at top of address space; same-cycle fetch+update; update mid-REQ
    phase_update = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'hFFFF_FFFC;
    tick();
    phase_update = 1'b1; jump_en_ex = 1'b0; phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("f3_addr_preupd", imem_addr, 32'hFFFF_FFFC);
    phase_update = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0200;
    tick();
    phase_update = 1'b0; jump_en_ex = 1'b0;
    chk("f3_addr_held", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    tick();
    imem_ack = 1'b0;
    chk_idle_outputs("f3", 32'h0000_0073, 32'hFFFF_FFFC, 32'h0);
    tick();
    phase_update = 1'b1;
    tick();
    phase_update = 1'b0; phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("f4_addr_wrap", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0010_0113;
    tick();
    imem_ack = 1'b0;
    chk_idle_outputs("f4", 32'h0010_0113, 32'h0, 32'h4);
    tick();

    // 4: misaligned jump target
    phase_update = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0102;
    tick();
    phase_update = 1'b0; jump_en_ex = 1'b0;
    chk("mis_err", 32'(misalign_err), 32'h1);
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("mis_blocked", 32'(imem_req), 32'h0);
    chk("mis_busy", 32'(fetch_busy), 32'h0);

    // 6: ack timeout, then reset in mid-request with a late ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_misalign", 32'(misalign_err), 32'h0);
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    chk("to_req_last", 32'(imem_req), 32'h1);
    chk("to_berr_early", 32'(bus_err), 32'h0);
    tick();
    chk("to_berr", 32'(bus_err), 32'h1);
    chk("to_req_off", 32'(imem_req), 32'h0);
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("to_blocked", 32'(imem_req), 32'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    chk("mid_req_up", 32'(imem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_req_drop", 32'(imem_req), 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("late_ack_done", 32'(fetch_done), 32'h0);
    chk_idle_outputs("late_ack", 32'h0000_0013, 32'h0, 32'h4);
    chk("late_ack_errs", {30'h0, misalign_err, bus_err}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
